// File: rtl/a2d_pkg.sv
// Shared constants and FSM state type for the A2D SPI responder.
package a2d_pkg;
  localparam int A2D_DATA_W  = 12;
  localparam int A2D_FRAME_W = 16;
  localparam int A2D_NUM_CH  = 8;
  localparam int CH_MSB      = 13;
  localparam int CH_LSB      = 11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } a2d_state_e;
endpackage

// File: rtl/spi_edge_sync.sv
// Two-flop synchronizer plus a third flop for rise/fall detection of a slow SPI input.
module spi_edge_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);
  logic r_q1, r_q2, r_q3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q1 <= RST_VAL;
      r_q2 <= RST_VAL;
      r_q3 <= RST_VAL;
    end else begin
      r_q1 <= i_async;
      r_q2 <= r_q1;
      r_q3 <= r_q2;
    end
  end

  assign o_sync = r_q2;
  assign o_rise = ~r_q3 & r_q2;
  assign o_fall = r_q3 & ~r_q2;
endmodule

// File: rtl/a2d_spi_resp.sv
// ADC128S-style SPI responder: the command in frame N selects the sample returned
// MSB-first on MISO in frame N+1; samples come from a parallel channel-data port.
module a2d_spi_resp
  import a2d_pkg::*;
#(
  parameter int DATA_W  = A2D_DATA_W,
  parameter int NUM_CH  = A2D_NUM_CH,
  parameter int FRAME_W = A2D_FRAME_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       SS_n,
  input  logic                       SCLK,
  input  logic                       MOSI,
  output logic                       MISO,
  input  logic [DATA_W*NUM_CH-1:0]   ch_data,
  output logic [$clog2(NUM_CH)-1:0]  chnnl,
  output logic                       cmd_vld,
  output logic                       frame_err
);
  localparam int          CH_W      = $clog2(NUM_CH);
  localparam logic [4:0]  CNT_FRAME = 5'(FRAME_W);

  a2d_state_e          r_state, w_state_nxt;
  logic                r_mosi_q1, r_mosi_q2;
  logic [4:0]          r_bit_cnt;
  logic [FRAME_W-1:0]  r_rx_shft, r_tx_shft;
  logic [DATA_W-1:0]   r_sample_q;
  logic [CH_W-1:0]     r_chnnl;
  logic                r_cmd_vld, r_frame_err;

  logic                w_ss_sync, w_ss_rise, w_ss_fall;
  logic                w_sclk_sync, w_sclk_rise, w_sclk_fall;
  logic                w_frame_start, w_frame_end;
  logic [CH_W-1:0]     w_cmd_ch;
  logic [FRAME_W-1:0]  w_resp_word;
  logic [DATA_W-1:0]   w_ch_arr [NUM_CH];

  spi_edge_sync #(.RST_VAL(1'b1)) u_ss_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_async(SS_n),
    .o_sync (w_ss_sync),
    .o_rise (w_ss_rise),
    .o_fall (w_ss_fall)
  );

  spi_edge_sync #(.RST_VAL(1'b1)) u_sclk_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_async(SCLK),
    .o_sync (w_sclk_sync),
    .o_rise (w_sclk_rise),
    .o_fall (w_sclk_fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mosi_q1 <= 1'b0;
      r_mosi_q2 <= 1'b0;
    end else begin
      r_mosi_q1 <= MOSI;
      r_mosi_q2 <= r_mosi_q1;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign w_ch_arr[k] = ch_data[k*DATA_W +: DATA_W];
  end

  assign w_cmd_ch      = r_rx_shft[CH_MSB:CH_LSB];
  assign w_resp_word   = {{(FRAME_W-DATA_W){1'b0}}, r_sample_q};
  assign w_frame_start = (r_state == ST_IDLE)  && w_ss_fall;
  assign w_frame_end   = (r_state == ST_SHIFT) && w_ss_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_ss_fall) w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (w_ss_rise) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Frame end takes priority, so an SCLK edge coinciding with SS_n rise is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt   <= '0;
      r_rx_shft   <= '0;
      r_tx_shft   <= '0;
      r_sample_q  <= '0;
      r_chnnl     <= '0;
      r_cmd_vld   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_cmd_vld   <= 1'b0;
      r_frame_err <= 1'b0;
      if (w_frame_start) begin
        r_bit_cnt <= '0;
        r_tx_shft <= w_resp_word;
      end else if (w_frame_end) begin
        if (r_bit_cnt == CNT_FRAME) begin
          r_chnnl    <= w_cmd_ch;
          r_sample_q <= w_ch_arr[w_cmd_ch];
          r_cmd_vld  <= 1'b1;
        end else begin
          r_frame_err <= 1'b1;
        end
      end else if (r_state == ST_SHIFT) begin
        if (w_sclk_rise) begin
          r_rx_shft <= {r_rx_shft[FRAME_W-2:0], r_mosi_q2};
          if (r_bit_cnt != 5'd31) r_bit_cnt <= r_bit_cnt + 5'd1;
        end
        // The leading fall of a frame keeps bit 15 in place for the first rise.
        if (w_sclk_fall && !w_sclk_sync && (r_bit_cnt != 5'd0))
          r_tx_shft <= {r_tx_shft[FRAME_W-2:0], 1'b0};
      end
    end
  end

  assign MISO      = ~w_ss_sync & r_tx_shft[FRAME_W-1];
  assign chnnl     = r_chnnl;
  assign cmd_vld   = r_cmd_vld;
  assign frame_err = r_frame_err;
endmodule

// File: tb/tb_a2d_spi_resp.sv
// Bench for a2d_spi_resp: a directed SPI master pushes expected MISO words and
// pulse events into queues; a monitor pops and compares as the DUT presents them.
module tb_a2d_spi_resp;
  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        SS_n = 1'b1;
  logic        SCLK = 1'b1;
  logic        MOSI = 1'b0;
  logic        MISO;
  logic [95:0] ch_data;
  logic [2:0]  chnnl;
  logic        cmd_vld;
  logic        frame_err;

  typedef struct packed {
    logic       is_err;
    logic [2:0] ch;
  } evt_t;

  evt_t        exp_evt[$];
  logic [15:0] exp_word[$];
  int          n_chk  = 0;
  int          n_pass = 0;

  a2d_spi_resp dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SS_n     (SS_n),
    .SCLK     (SCLK),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .ch_data  (ch_data),
    .chnnl    (chnnl),
    .cmd_vld  (cmd_vld),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic push(input logic [15:0] word, input logic has_word, input logic is_err,
                      input logic [2:0] ch);
    evt_t e;
    e.is_err = is_err;
    e.ch     = ch;
    if (has_word) exp_word.push_back(word);
    exp_evt.push_back(e);
  endtask

  // act: 0 none, 1 change ch3 sample mid-frame, 2 assert reset mid-frame
  task automatic frame(input logic [15:0] mosi, input int nrise, input int act_at, input int act);
    @(negedge clk);
    SS_n = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < nrise; i++) begin
      SCLK = 1'b0;
      MOSI = mosi[15-i];
      repeat (HALF) @(negedge clk);
      SCLK = 1'b1;
      repeat (HALF) @(negedge clk);
      if (i + 1 == act_at && act == 1) ch_data[36 +: 12] = 12'h3FF;
      if (i + 1 == act_at && act == 2) begin
        rst_n = 1'b0;
        #1;
        check("rst_miso", {31'd0, MISO}, 32'd0);
        check("rst_chnnl", {29'd0, chnnl}, 32'd0);
        check("rst_cmd_vld", {31'd0, cmd_vld}, 32'd0);
        SS_n = 1'b1;
        MOSI = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (2*HALF) @(negedge clk);
        return;
      end
    end
    repeat (HALF) @(negedge clk);
    SS_n = 1'b1;
    MOSI = 1'b0;
    repeat (3*HALF) @(negedge clk);
  endtask

  // Monitor: reassembles each 16-bit MISO word and checks cmd_vld/frame_err pulses.
  initial begin
    logic [15:0] mon_sh = '0;
    int          mon_n = 0;
    logic        prev_ss = 1'b1;
    logic        prev_sclk = 1'b1;
    evt_t        e;
    logic [15:0] w;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        mon_n     = 0;
        prev_ss   = 1'b1;
        prev_sclk = 1'b1;
      end else begin
        if (prev_ss && !SS_n) begin
          mon_n  = 0;
          mon_sh = '0;
        end
        if (!SS_n && !prev_sclk && SCLK) begin
          mon_sh = {mon_sh[14:0], MISO};
          mon_n++;
        end
        if (!prev_ss && SS_n && mon_n == 16) begin
          if (exp_word.size() == 0) begin
            n_chk++;
            $display("FAIL miso_word_unexpected: got %h, expected none", mon_sh);
          end else begin
            w = exp_word.pop_front();
            check("miso_word", {16'd0, mon_sh}, {16'd0, w});
          end
        end
        if (cmd_vld || frame_err) begin
          if (exp_evt.size() == 0) begin
            n_chk++;
            $display("FAIL pulse_unexpected: got cmd_vld=%b frame_err=%b, expected none",
                     cmd_vld, frame_err);
          end else begin
            e = exp_evt.pop_front();
            check("pulse_kind", {30'd0, cmd_vld, frame_err},
                  e.is_err ? 32'd1 : 32'd2);
            check("pulse_chnnl", {29'd0, chnnl}, {29'd0, e.ch});
          end
        end
        prev_ss   = SS_n;
        prev_sclk = SCLK;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] sweep_mosi [8];
    logic [15:0] sweep_exp  [8];
    sweep_mosi = '{16'h0000, 16'h0800, 16'h1000, 16'h1800,
                   16'h2000, 16'hEFFF, 16'h3000, 16'h3800};
    sweep_exp  = '{16'h0A5C, 16'h0000, 16'h0101, 16'h0202,
                   16'h0A5C, 16'h0404, 16'h0505, 16'h0606};
    ch_data = {12'h707, 12'h606, 12'h505, 12'h404, 12'hA5C, 12'h202, 12'h101, 12'h000};

    repeat (5) @(negedge clk);
    check("reset_chnnl", {29'd0, chnnl}, 32'd0);
    check("reset_miso", {31'd0, MISO}, 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("idle_cmd_vld", {31'd0, cmd_vld}, 32'd0);
    check("idle_frame_err", {31'd0, frame_err}, 32'd0);

    push(16'h0000, 1'b1, 1'b0, 3'd3); frame(16'h1800, 16, 0, 0);
    push(16'h0A5C, 1'b1, 1'b0, 3'd3); frame(16'h1800, 16, 0, 0);
    for (int k = 0; k < 8; k++) begin
      push(sweep_exp[k], 1'b1, 1'b0, 3'(k));
      frame(sweep_mosi[k], 16, 0, 0);
    end
    check("sweep_chnnl", {29'd0, chnnl}, 32'd7);

    push(16'h0000, 1'b0, 1'b1, 3'd7); frame(16'h2800, 9, 0, 0);
    check("trunc_chnnl", {29'd0, chnnl}, 32'd7);
    push(16'h0707, 1'b1, 1'b0, 3'd3); frame(16'h1800, 16, 0, 0);

    push(16'h0A5C, 1'b1, 1'b0, 3'd3); frame(16'h1800, 16, 5, 1);
    push(16'h03FF, 1'b1, 1'b0, 3'd3); frame(16'h1800, 16, 0, 0);

    frame(16'h1000, 16, 8, 2);
    push(16'h0000, 1'b1, 1'b0, 3'd2); frame(16'h1000, 16, 0, 0);
    push(16'h0202, 1'b1, 1'b0, 3'd0); frame(16'h0000, 16, 0, 0);
    push(16'h0000, 1'b0, 1'b1, 3'd0); frame(16'h0000, 0, 0, 0);

    repeat (20) @(negedge clk);
    check("exp_word_left", exp_word.size(), 32'd0);
    check("exp_evt_left", exp_evt.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
